// File: rtl/memoria_voltas_pkg.sv
// Shared stopwatch definitions for the lap store: default BCD time width,
// default lap depth and the BCD zero constant.
package memoria_voltas_pkg;

   localparam int unsigned TIME_WIDTH = 16;
   localparam int unsigned LAP_DEPTH  = 8;
   localparam logic [TIME_WIDTH-1:0] BCD_ZERO = TIME_WIDTH'(0);

endpackage

// File: rtl/memoria_banco.sv
// DEPTH x DATA_WIDTH register file.
// It writes on the clock edge and reads without a clock (asynchronous read).
module memoria_banco #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (write_enable) mem[write_addr] <= write_data;
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/memoria_voltas.sv
// Circular lap-time store.
// Holds the write pointer and the entry count, and lets the display read any lap by relative index.
module memoria_voltas
   import memoria_voltas_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = TIME_WIDTH,
   parameter int unsigned DEPTH      = LAP_DEPTH,
   parameter bit          OVERWRITE  = 1'b1,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] read_index,
   input  logic                  read_order,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  read_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  dropped
);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  dropped_q;
   logic                  accept;
   logic                  wipe;
   logic [ADDR_WIDTH-1:0] phys;
   logic [DATA_WIDTH-1:0] bank_data;

   assign full   = (count_q == (ADDR_WIDTH+1)'(DEPTH));
   assign wipe   = reset | clear;
   assign accept = write_enable & ~wipe & (~full | OVERWRITE);

   // Reset and clear both only rewind the pointer and count.
   // Stale array contents stay hidden because read_valid masks them.
   always_ff @(posedge clock) begin
      if (wipe) begin
         wr_ptr    <= '0;
         count_q   <= '0;
         dropped_q <= 1'b0;
      end else begin
         dropped_q <= write_enable & full & ~OVERWRITE;
         if (accept) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (!full) count_q <= count_q + (ADDR_WIDTH+1)'(1);
         end
      end
   end

   // When count == DEPTH, its truncated low bits are zero.
   // The oldest lap then sits at wr_ptr itself.
   always_comb begin
      phys = wr_ptr - ADDR_WIDTH'(1) - read_index;
      if (read_order) phys = wr_ptr - count_q[ADDR_WIDTH-1:0] + read_index;
   end

   memoria_banco #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_banco (
      .clock        (clock),
      .write_enable (accept),
      .write_addr   (wr_ptr),
      .write_data   (data_in),
      .read_addr    (phys),
      .read_data    (bank_data)
   );

   assign read_valid = ({1'b0, read_index} < count_q);
   assign data_out   = read_valid ? bank_data : DATA_WIDTH'(BCD_ZERO);
   assign count      = count_q;
   assign dropped    = dropped_q;

endmodule

// File: tb/tb_memoria_voltas.sv
// Bench for memoria_voltas at DEPTH=4, with both overwrite policies side by side.
// Expected values come from lap queues kept inside the bench.
`timescale 1ns/100ps
module tb_memoria_voltas;

   localparam int unsigned DW = 16;
   localparam int unsigned DP = 4;
   localparam int unsigned AW = 2;

   logic          clock = 1'b0;
   logic          reset, write_enable, clear, read_order;
   logic [DW-1:0] data_in;
   logic [AW-1:0] read_index;

   logic [DW-1:0] dout_ow, dout_dr;
   logic          rv_ow, rv_dr, full_ow, full_dr, drop_ow, drop_dr;
   logic [AW:0]   cnt_ow, cnt_dr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] q_ow[$];
   logic [DW-1:0] q_dr[$];
   bit            exp_drop;

   always #50 clock = ~clock;

   memoria_voltas #(.DATA_WIDTH(DW), .DEPTH(DP), .OVERWRITE(1'b1)) u_ow (
      .clock(clock), .reset(reset), .write_enable(write_enable), .data_in(data_in),
      .clear(clear), .read_index(read_index), .read_order(read_order),
      .data_out(dout_ow), .read_valid(rv_ow), .count(cnt_ow), .full(full_ow),
      .dropped(drop_ow));

   memoria_voltas #(.DATA_WIDTH(DW), .DEPTH(DP), .OVERWRITE(1'b0)) u_dr (
      .clock(clock), .reset(reset), .write_enable(write_enable), .data_in(data_in),
      .clear(clear), .read_index(read_index), .read_order(read_order),
      .data_out(dout_dr), .read_valid(rv_dr), .count(cnt_dr), .full(full_dr),
      .dropped(drop_dr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one clock with the given controls and advance the lap queues.
   task automatic do_cycle(input bit rst, input bit clr, input bit we, input logic [DW-1:0] d);
      reset = rst; clear = clr; write_enable = we; data_in = d;
      @(posedge clock);
      exp_drop = 1'b0;
      if (rst || clr) begin
         q_ow.delete();
         q_dr.delete();
      end else if (we) begin
         q_ow.push_back(d);
         if (q_ow.size() > DP) void'(q_ow.pop_front());
         if (q_dr.size() < DP) q_dr.push_back(d);
         else exp_drop = 1'b1;
      end
      #1;
      reset = 1'b0; clear = 1'b0; write_enable = 1'b0;
   endtask

   function automatic logic [DW-1:0] lap(input logic [DW-1:0] q[$], input int ord, input int idx);
      if (idx >= q.size()) return '0;
      return (ord == 0) ? q[q.size()-1-idx] : q[idx];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, " count_ow"}, 32'(cnt_ow), 32'(q_ow.size()));
      chk({tag, " count_dr"}, 32'(cnt_dr), 32'(q_dr.size()));
      chk({tag, " full_ow"}, 32'(full_ow), 32'(q_ow.size() == DP));
      chk({tag, " full_dr"}, 32'(full_dr), 32'(q_dr.size() == DP));
      chk({tag, " dropped_ow"}, 32'(drop_ow), 32'(0));
      chk({tag, " dropped_dr"}, 32'(drop_dr), 32'(exp_drop));
      for (int o = 0; o < 2; o++) begin
         for (int i = 0; i < int'(DP); i++) begin
            read_order = o[0];
            read_index = AW'(i);
            #1;
            chk($sformatf("%s ow o%0d i%0d data", tag, o, i), 32'(dout_ow), 32'(lap(q_ow, o, i)));
            chk($sformatf("%s dr o%0d i%0d data", tag, o, i), 32'(dout_dr), 32'(lap(q_dr, o, i)));
            chk($sformatf("%s ow o%0d i%0d valid", tag, o, i), 32'(rv_ow), 32'(i < q_ow.size()));
            chk($sformatf("%s dr o%0d i%0d valid", tag, o, i), 32'(rv_dr), 32'(i < q_dr.size()));
         end
      end
   endtask

   task automatic peek(input bit ord, input int idx, output logic [DW-1:0] ow, output logic [DW-1:0] dr);
      read_order = ord;
      read_index = AW'(idx);
      #1;
      ow = dout_ow;
      dr = dout_dr;
   endtask

   typedef struct {
      bit            rst, clr, we;
      logic [DW-1:0] din;
      int            c_ow, c_dr;
      bit            drop;
      logic [DW-1:0] new_ow, old_ow, new_dr, old_dr;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [DW-1:0] a, b;
      reset = 1'b1; clear = 1'b0; write_enable = 1'b0; data_in = '0;
      read_index = '0; read_order = 1'b0; exp_drop = 1'b0;

      //           rst clr we  din     cow cdr drp new_ow  old_ow  new_dr  old_dr
      vecs.push_back('{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      vecs.push_back('{0, 0, 1, 16'h0012, 1, 1, 0, 16'h0012, 16'h0012, 16'h0012, 16'h0012});
      vecs.push_back('{0, 0, 1, 16'h0034, 2, 2, 0, 16'h0034, 16'h0012, 16'h0034, 16'h0012});
      vecs.push_back('{0, 0, 1, 16'h0056, 3, 3, 0, 16'h0056, 16'h0012, 16'h0056, 16'h0012});
      vecs.push_back('{0, 0, 1, 16'h0078, 4, 4, 0, 16'h0078, 16'h0012, 16'h0078, 16'h0012});
      vecs.push_back('{0, 0, 1, 16'h009A, 4, 4, 1, 16'h009A, 16'h0034, 16'h0078, 16'h0012});
      vecs.push_back('{0, 0, 0, 16'h0000, 4, 4, 0, 16'h009A, 16'h0034, 16'h0078, 16'h0012});
      vecs.push_back('{0, 1, 1, 16'h0099, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      vecs.push_back('{0, 0, 1, 16'h0077, 1, 1, 0, 16'h0077, 16'h0077, 16'h0077, 16'h0077});
      vecs.push_back('{0, 0, 1, 16'h0011, 2, 2, 0, 16'h0011, 16'h0077, 16'h0011, 16'h0077});
      vecs.push_back('{1, 0, 1, 16'h0022, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      vecs.push_back('{0, 0, 1, 16'h0033, 1, 1, 0, 16'h0033, 16'h0033, 16'h0033, 16'h0033});

      foreach (vecs[k]) begin
         do_cycle(vecs[k].rst, vecs[k].clr, vecs[k].we, vecs[k].din);
         chk($sformatf("vec%0d count_ow", k), 32'(cnt_ow), 32'(vecs[k].c_ow));
         chk($sformatf("vec%0d count_dr", k), 32'(cnt_dr), 32'(vecs[k].c_dr));
         chk($sformatf("vec%0d dropped_dr", k), 32'(drop_dr), 32'(vecs[k].drop));
         peek(1'b0, 0, a, b);
         chk($sformatf("vec%0d newest_ow", k), 32'(a), 32'(vecs[k].new_ow));
         chk($sformatf("vec%0d newest_dr", k), 32'(b), 32'(vecs[k].new_dr));
         peek(1'b1, 0, a, b);
         chk($sformatf("vec%0d oldest_ow", k), 32'(a), 32'(vecs[k].old_ow));
         chk($sformatf("vec%0d oldest_dr", k), 32'(b), 32'(vecs[k].old_dr));
         check_all($sformatf("vec%0d", k));
      end

      // Write 1..5 after reset: overwrite versus drop policy, with a one-cycle dropped pulse.
      do_cycle(1, 0, 0, '0);
      for (int v = 1; v <= 5; v++) do_cycle(0, 0, 1, DW'(v));
      chk("seq dropped_pulse", 32'(drop_dr), 32'(1));
      chk("seq full_ow", 32'(full_ow), 32'(1));
      chk("seq count_dr", 32'(cnt_dr), 32'(4));
      peek(1'b1, 0, a, b);
      chk("seq oldest_ow", 32'(a), 32'h0002);
      peek(1'b0, 0, a, b);
      chk("seq newest_ow", 32'(a), 32'h0005);
      chk("seq newest_dr", 32'(b), 32'h0004);
      do_cycle(0, 0, 0, '0);
      chk("seq dropped_low", 32'(drop_dr), 32'(0));
      check_all("seq");

      // Reset arriving right after a dropped write also clears the pulse.
      do_cycle(0, 0, 1, 16'h0006);
      do_cycle(1, 0, 0, '0);
      chk("rst dropped", 32'(drop_dr), 32'(0));
      chk("rst full_dr", 32'(full_dr), 32'(0));
      do_cycle(0, 0, 1, 16'h4321);
      check_all("rst");

      // Random traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         do_cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1), DW'($urandom));
         check_all($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
